// File: rtl/macc_matrix_port_if.sv
// macc_matrix_port_if
// Host-side word stream for one matrix port of the matrix accelerator.
//   master : host driving clr/wen/ren/data_in and observing port status
//   slave  : the storage port itself
// Signals:
//   clr        flush request (empties port, clears error flags)
//   wen/ren    write/read enables
//   data_in    element to write
//   data_out   head element (0 when empty)
//   count      stored element count
//   full/empty fill status
//   wr_row/col row-major position of the next write slot
//   load_done  one-cycle pulse when the matrix becomes fully loaded
//   ovf_err    sticky write-while-full flag
//   unf_err    sticky read-while-empty flag
interface macc_matrix_port_if #(
    parameter int DIM   = 4,
    parameter int WIDTH = 32
);
    localparam int DEPTH = DIM * DIM;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(DIM);

    logic             clr;
    logic             wen;
    logic             ren;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic [RW-1:0]    wr_row;
    logic [RW-1:0]    wr_col;
    logic             load_done;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output clr, wen, ren, data_in,
        input  data_out, count, full, empty, wr_row, wr_col,
               load_done, ovf_err, unf_err
    );

    modport slave (
        input  clr, wen, ren, data_in,
        output data_out, count, full, empty, wr_row, wr_col,
               load_done, ovf_err, unf_err
    );
endinterface

// File: rtl/macc_matrix_port.sv
// macc_matrix_port
// Holds one DIM x DIM matrix (row-major) as a circular buffer and presents
// the head element first-word-fall-through style.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  macc_matrix_port_if slave modport (see interface file for signals)
module macc_matrix_port #(
    parameter int DIM   = 4,
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    macc_matrix_port_if.slave   bus
);
    localparam int DEPTH = DIM * DIM;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(DIM);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [RW-1:0]    wr_row;
    logic [RW-1:0]    wr_col;
    logic             load_done;
    logic             ovf_err;
    logic             unf_err;

    logic full;
    logic empty;
    logic flush;
    logic wr_ok;
    logic rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign flush = rst || bus.clr;
    // Acceptance is judged on pre-edge fill state, so a write while full is
    // dropped even when a read frees a slot in the same cycle.
    assign wr_ok = bus.wen && !full;
    assign rd_ok = bus.ren && !empty;

    // Array is deliberately left out of reset/flush; only the pointers move.
    always_ff @(posedge clk) begin
        if (!flush && wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
            load_done <= 1'b0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (wr_col == RW'(DIM - 1)) begin
                    wr_col <= '0;
                    wr_row <= (wr_row == RW'(DIM - 1)) ? '0 : wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Only a lone write can take the count from DEPTH-1 to DEPTH.
            load_done <= wr_ok && !rd_ok && (count == CW'(DEPTH - 1));
            if (bus.wen && full) begin
                ovf_err <= 1'b1;
            end
            if (bus.ren && empty) begin
                unf_err <= 1'b1;
            end
        end
    end

    assign bus.data_out  = empty ? '0 : mem[rd_ptr];
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.wr_row    = wr_row;
    assign bus.wr_col    = wr_col;
    assign bus.load_done = load_done;
    assign bus.ovf_err   = ovf_err;
    assign bus.unf_err   = unf_err;
endmodule

// File: tb/tb_macc_matrix_port.sv
module tb_macc_matrix_port;
    logic clk = 1'b0;
    logic rst = 1'b1;

    macc_matrix_port_if #(.DIM(4), .WIDTH(32)) bus ();

    macc_matrix_port #(.DIM(4), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        wen;
        logic        ren;
        logic [31:0] din;
        logic [31:0] exp_do;
        logic [4:0]  exp_cnt;
        logic        exp_full;
        logic        exp_empty;
        logic [1:0]  exp_row;
        logic [1:0]  exp_col;
        logic        exp_ld;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [31:0] d);
        bus.clr     = c;
        bus.wen     = w;
        bus.ren     = r;
        bus.data_in = d;
        @(posedge clk);
        @(negedge clk);
        bus.clr = 1'b0;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_do, input logic [4:0] e_cnt,
                           input logic e_full, input logic e_empty, input logic [1:0] e_row,
                           input logic [1:0] e_col, input logic e_ld, input logic e_ovf,
                           input logic e_unf);
        chk({tag, ".data_out"},  bus.data_out,           e_do);
        chk({tag, ".count"},     32'(bus.count),         32'(e_cnt));
        chk({tag, ".full"},      32'(bus.full),          32'(e_full));
        chk({tag, ".empty"},     32'(bus.empty),         32'(e_empty));
        chk({tag, ".wr_row"},    32'(bus.wr_row),        32'(e_row));
        chk({tag, ".wr_col"},    32'(bus.wr_col),        32'(e_col));
        chk({tag, ".load_done"}, 32'(bus.load_done),     32'(e_ld));
        chk({tag, ".ovf_err"},   32'(bus.ovf_err),       32'(e_ovf));
        chk({tag, ".unf_err"},   32'(bus.unf_err),       32'(e_unf));
    endtask

    function automatic vec_t mk(input logic c, input logic w, input logic r, input logic [31:0] d,
                                input logic [31:0] e_do, input logic [4:0] e_cnt,
                                input logic e_full, input logic e_empty, input logic [1:0] e_row,
                                input logic [1:0] e_col, input logic e_ld, input logic e_ovf,
                                input logic e_unf);
        vec_t v;
        v.clr = c; v.wen = w; v.ren = r; v.din = d;
        v.exp_do = e_do; v.exp_cnt = e_cnt; v.exp_full = e_full; v.exp_empty = e_empty;
        v.exp_row = e_row; v.exp_col = e_col; v.exp_ld = e_ld; v.exp_ovf = e_ovf;
        v.exp_unf = e_unf;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        // single write/pop, underflow, simultaneous ren+wen when empty, flush
        tbl[0]  = mk(0,1,0,32'hdeadbeef, 32'hdeadbeef,1,0,0, 0,1, 0,0,0);
        tbl[1]  = mk(0,0,1,32'h0,        32'h0,       0,0,1, 0,1, 0,0,0);
        tbl[2]  = mk(0,0,1,32'h0,        32'h0,       0,0,1, 0,1, 0,0,1);
        tbl[3]  = mk(0,1,1,32'h5,        32'h5,       1,0,0, 0,2, 0,0,1);
        tbl[4]  = mk(1,0,0,32'h0,        32'h0,       0,0,1, 0,0, 0,0,0);
        // flush mid-load with errors pending and a write in the same cycle
        tbl[5]  = mk(0,0,1,32'h0,        32'h0,       0,0,1, 0,0, 0,0,1);
        tbl[6]  = mk(0,1,0,32'h300,      32'h300,     1,0,0, 0,1, 0,0,1);
        tbl[7]  = mk(0,1,0,32'h301,      32'h300,     2,0,0, 0,2, 0,0,1);
        tbl[8]  = mk(0,1,0,32'h302,      32'h300,     3,0,0, 0,3, 0,0,1);
        tbl[9]  = mk(0,1,0,32'h303,      32'h300,     4,0,0, 1,0, 0,0,1);
        tbl[10] = mk(0,1,0,32'h304,      32'h300,     5,0,0, 1,1, 0,0,1);
        tbl[11] = mk(0,1,0,32'h305,      32'h300,     6,0,0, 1,2, 0,0,1);
        tbl[12] = mk(0,1,0,32'h306,      32'h300,     7,0,0, 1,3, 0,0,1);
        tbl[13] = mk(1,1,0,32'h3ff,      32'h0,       0,0,1, 0,0, 0,0,0);
        tbl[14] = mk(0,1,0,32'h400,      32'h400,     1,0,0, 0,1, 0,0,0);
        tbl[15] = mk(1,0,0,32'h0,        32'h0,       0,0,1, 0,0, 0,0,0);

        bus.clr = 1'b0;
        bus.wen = 1'b1;
        bus.ren = 1'b0;
        bus.data_in = 32'hffff_ffff;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 32'h0, 0, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        bus.wen = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].clr, tbl[i].wen, tbl[i].ren, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].exp_do, tbl[i].exp_cnt, tbl[i].exp_full,
                    tbl[i].exp_empty, tbl[i].exp_row, tbl[i].exp_col, tbl[i].exp_ld,
                    tbl[i].exp_ovf, tbl[i].exp_unf);
        end

        // full load: slot position walks row-major and wraps to (0,0)
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 32'h100 + i);
            chk_all($sformatf("load%0d", i), 32'h100, 5'(i + 1), (i == 15), 0,
                    2'(((i + 1) % 16) / 4), 2'((i + 1) % 4), (i == 15), 0, 0);
        end
        step(0, 0, 0, 32'h0);
        chk("load_done_one_cycle", 32'(bus.load_done), 32'h0);

        // overflow alone, then overflow with a concurrent read
        step(0, 1, 0, 32'hbad0bad0);
        chk_all("ovf", 32'h100, 16, 1, 0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 32'hbad0bad0);
        chk_all("ovf_rd", 32'h101, 15, 0, 0, 0, 0, 0, 1, 0);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("drain_head%0d", j), bus.data_out, 32'h101 + j);
            step(0, 0, 1, 32'h0);
        end
        chk_all("drained", 32'h0, 0, 0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 32'h0);
        chk_all("clr2", 32'h0, 0, 0, 1, 0, 0, 0, 0, 0);

        // concurrent traffic across the pointer wrap
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h200 + i);
        chk_all("preload", 32'h200, 3, 0, 0, 0, 3, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1, 32'h203 + k);
            chk_all($sformatf("wrap%0d", k), 32'h200 + k + 1, 3, 0, 0,
                    2'(((4 + k) % 16) / 4), 2'((4 + k) % 4), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
